pmem_responder: RTL and testbench
=================================

Name: pmem_responder

Overview:
- Synthesizable program-memory responder: the memory end of the multi-channel program-memory read interface (mem_read_valid/address -> mem_read_ready/data) driven by pmem_cache and the pmem controllers.
- Holds instruction storage in a single-port array with a configurable per-request latency.
- Round-robin arbitration across channels for the one array read port.
- A load port fills the array before kernel launch.

Parameters:
- ADDR_BITS, 8, address width.
- DATA_BITS, 16, instruction word width.
- NUM_CHANNELS, 1, independent request channels.
- DEPTH, 256, words of storage (<= 2**ADDR_BITS).
- READ_LATENCY, 2, wait cycles after accept before a channel may contend for the array (0 allowed).

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- mem_read_valid  in  NUM_CHANNELS  per-channel request; held high with stable address until ready seen
- mem_read_address  in  ADDR_BITS x NUM_CHANNELS  request address
- mem_read_ready  out  NUM_CHANNELS  one-cycle response pulse
- mem_read_data  out  DATA_BITS x NUM_CHANNELS  response word, valid while ready=1, else 0
- load_valid  in  1  array write strobe
- load_address  in  ADDR_BITS  write address
- load_data  in  DATA_BITS  write data

Behaviour:
- Reset:
  - mem_read_ready=0 and all mem_read_data=0.
  - All channels go to IDLE, latency counters 0, rr pointer 0.
  - Array contents are NOT cleared.
  - Reset mid-request abandons it; no ready is ever issued for it.
- Per-channel FSM, all transitions on clk:
  - IDLE: valid=1 -> latch address, cnt<=READ_LATENCY, go WAIT.
  - WAIT:
    - cnt>0 -> cnt<=cnt-1.
    - cnt==0 -> channel is eligible.
    - If granted -> data<=array[addr] (or 0 if addr>=DEPTH), ready<=1, go RESP.
    - If not granted -> stay WAIT.
  - RESP: ready<=0, data<=0, go HOLD. Ready is high exactly one cycle.
  - HOLD: valid=0 -> IDLE. Prevents double service if a requester holds valid late.
- Latency: uncontended, ready is visible READ_LATENCY+1 cycles after the edge that accepted valid.
- Minimum request-to-request spacing on one channel: accept, WAIT x(L+1), RESP, HOLD, IDLE.
- Address is captured at accept. Later address changes while busy are ignored.
- Arbitration:
  - One array access per cycle.
  - Grant goes to the lowest eligible index >= rr_ptr, wrapping modulo NUM_CHANNELS.
  - On a grant, rr_ptr<=grant+1 (wrap to 0). No eligible channel -> rr_ptr unchanged.
- Load port:
  - load_valid has priority over reads: that cycle no read grant is issued and eligible channels stay in WAIT.
  - Writes with load_address>=DEPTH are dropped.
  - Same-cycle load and pending read to the same address: the read is stalled, so it returns the new data next cycle.
- Counter width: $clog2(READ_LATENCY+1), minimum 1.

Optional Feature:
- PMEM_RESP_STATS_EN defined:
  - Adds outputs stat_responses[31:0], which increments on every ready pulse (summed over channels, at most 1 per cycle).
  - Adds stat_stall_cycles[31:0], which increments each cycle at least one channel is eligible but ungranted (load priority or lost arbitration).
  - Both counters saturate at all-ones and reset to 0.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- pmem_pkg: ch_state_t enum (IDLE, WAIT, RESP, HOLD) and the latency-counter width helper function.
- Sub-module pmem_rr_arbiter (NUM_CHANNELS): inputs req vector, enable (=!load_valid) and rr_ptr; outputs one-hot grant and next pointer. Combinational grant, registered pointer.

Test Plan:
- Load 0x1234 at addr 5, L=2, ch0 valid addr 5 at cycle 0 -> ch0 ready=1, data=0x1234 at cycle 3 only; data=0 at cycle 4.
- NUM_CHANNELS=2, both request addr 1 (0xAAAA) and addr 2 (0xBBBB) in the same cycle, rr_ptr=0 -> ch0 responds at cycle L+1, ch1 at L+2; a repeat pair sees the same order (ptr returned to 0).
- Request addr 0x80 with DEPTH=64 -> ready pulse with data=0x0000.
- load_valid held 3 cycles overlapping ch0 eligibility -> ch0 ready delayed exactly 3 cycles; with PMEM_RESP_STATS_EN, stat_stall_cycles=3 and stat_responses=1.
- Requester holds valid 4 cycles past ready -> only one ready pulse; new request accepted 1 cycle after valid drops.
- Reset asserted while ch0 in WAIT -> no ready ever for that request; the array still returns previously loaded 0x1234 on a fresh request.

Source files
------------

// File: rtl/pmem_pkg.sv
// Shared types for the program-memory responder: per-channel state encoding
// and the latency-counter width helper.
package pmem_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP,
    HOLD
  } ch_state_t;

  // Latency counter has to hold READ_LATENCY itself; never narrower than one bit.
  function automatic int cnt_width(input int latency);
    int w;
    w = $clog2(latency + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/pmem_rr_arbiter.sv
// Round-robin arbiter for the single array read port: combinational one-hot
// grant starting at rr_ptr, plus the pointer value to register after a grant.
module pmem_rr_arbiter #(
  parameter int NUM_CHANNELS = 1,
  parameter int PTR_BITS     = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic [NUM_CHANNELS-1:0] req,
  input  logic                    enable,
  input  logic [PTR_BITS-1:0]     rr_ptr,
  output logic [NUM_CHANNELS-1:0] grant,
  output logic [PTR_BITS-1:0]     next_ptr
);

  always_comb begin
    logic found;
    int   pos;
    grant    = '0;
    next_ptr = rr_ptr;
    found    = 1'b0;
    pos      = 0;
    for (int k = 0; k < NUM_CHANNELS; k++) begin
      pos = int'(rr_ptr) + k;
      if (pos >= NUM_CHANNELS) pos = pos - NUM_CHANNELS;
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        if (enable && !found && req[c] && (c == pos)) begin
          grant[c] = 1'b1;
          found    = 1'b1;
          next_ptr = (c == NUM_CHANNELS - 1) ? '0 : PTR_BITS'(c + 1);
        end
      end
    end
  end

endmodule

// File: rtl/pmem_responder.sv
// Program-memory responder: load-filled single-port array served to several
// read channels with fixed latency and round-robin arbitration.
// Optional PMEM_RESP_STATS_EN adds saturating response / stall counters.
// state | meaning
// IDLE  | waiting for mem_read_valid
// WAIT  | latency countdown, eligible for the array once cnt==0
// RESP  | ready/data pulse is on the outputs
// HOLD  | wait for the requester to drop valid
module pmem_responder
  import pmem_pkg::*;
#(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 16,
  parameter int NUM_CHANNELS = 1,
  parameter int DEPTH        = 256,
  parameter int READ_LATENCY = 2
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic [NUM_CHANNELS-1:0]                 mem_read_valid,
  input  logic [NUM_CHANNELS-1:0][ADDR_BITS-1:0]  mem_read_address,
  output logic [NUM_CHANNELS-1:0]                 mem_read_ready,
  output logic [NUM_CHANNELS-1:0][DATA_BITS-1:0]  mem_read_data,
  input  logic                                    load_valid,
  input  logic [ADDR_BITS-1:0]                    load_address,
  input  logic [DATA_BITS-1:0]                    load_data
`ifdef PMEM_RESP_STATS_EN
  ,
  output logic [31:0]                             stat_responses,
  output logic [31:0]                             stat_stall_cycles
`endif
);

  localparam int CNT_BITS = cnt_width(READ_LATENCY);
  localparam int PTR_BITS = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
  localparam int MEM_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_BITS-1:0] mem [DEPTH];

  ch_state_t            state_q [NUM_CHANNELS];
  ch_state_t            state_d [NUM_CHANNELS];
  logic [CNT_BITS-1:0]  cnt_q   [NUM_CHANNELS];
  logic [CNT_BITS-1:0]  cnt_d   [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_q  [NUM_CHANNELS];
  logic [ADDR_BITS-1:0] addr_d  [NUM_CHANNELS];

  logic [NUM_CHANNELS-1:0]                eligible;
  logic [NUM_CHANNELS-1:0]                grant;
  logic [NUM_CHANNELS-1:0]                ready_d;
  logic [NUM_CHANNELS-1:0][DATA_BITS-1:0] data_d;
  logic [PTR_BITS-1:0]                    rr_ptr;
  logic [PTR_BITS-1:0]                    rr_next;
  logic [ADDR_BITS-1:0]                   rd_addr;
  logic [DATA_BITS-1:0]                   rd_word;

  always_comb begin
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      eligible[c] = (state_q[c] == WAIT) && (cnt_q[c] == '0);
    end
  end

  // A load cycle owns the array, so no read grant is issued that cycle.
  pmem_rr_arbiter #(
    .NUM_CHANNELS (NUM_CHANNELS),
    .PTR_BITS     (PTR_BITS)
  ) u_arb (
    .req      (eligible),
    .enable   (!load_valid),
    .rr_ptr   (rr_ptr),
    .grant    (grant),
    .next_ptr (rr_next)
  );

  always_comb begin
    rd_addr = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      if (grant[c]) rd_addr = addr_q[c];
    end
    rd_word = (int'(rd_addr) < DEPTH) ? mem[rd_addr[MEM_BITS-1:0]] : '0;
  end

  always_ff @(posedge clk) begin
    if (load_valid && (int'(load_address) < DEPTH)) begin
      mem[load_address[MEM_BITS-1:0]] <= load_data;
    end
  end

  always_comb begin
    ready_d = '0;
    data_d  = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      state_d[c] = state_q[c];
      cnt_d[c]   = cnt_q[c];
      addr_d[c]  = addr_q[c];
      unique case (state_q[c])
        IDLE: begin
          if (mem_read_valid[c]) begin
            addr_d[c]  = mem_read_address[c];
            cnt_d[c]   = CNT_BITS'(READ_LATENCY);
            state_d[c] = WAIT;
          end
        end
        WAIT: begin
          if (cnt_q[c] != '0) begin
            cnt_d[c] = cnt_q[c] - CNT_BITS'(1);
          end else if (grant[c]) begin
            ready_d[c] = 1'b1;
            data_d[c]  = rd_word;
            state_d[c] = RESP;
          end
        end
        RESP: state_d[c] = HOLD;
        HOLD: begin
          if (!mem_read_valid[c]) state_d[c] = IDLE;
        end
        default: state_d[c] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= IDLE;
        cnt_q[c]   <= '0;
        addr_q[c]  <= '0;
      end
      mem_read_ready <= '0;
      mem_read_data  <= '0;
      rr_ptr         <= '0;
    end else begin
      for (int c = 0; c < NUM_CHANNELS; c++) begin
        state_q[c] <= state_d[c];
        cnt_q[c]   <= cnt_d[c];
        addr_q[c]  <= addr_d[c];
      end
      mem_read_ready <= ready_d;
      mem_read_data  <= data_d;
      rr_ptr         <= rr_next;
    end
  end

`ifdef PMEM_RESP_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_responses    <= '0;
      stat_stall_cycles <= '0;
    end else begin
      if ((|grant) && (stat_responses != '1)) begin
        stat_responses <= stat_responses + 32'd1;
      end
      if ((|(eligible & ~grant)) && (stat_stall_cycles != '1)) begin
        stat_stall_cycles <= stat_stall_cycles + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pmem_responder.sv
// Self-checking bench for pmem_responder (2 channels, 64 words, latency 2):
// directed scenarios plus randomized traffic against a timing-level model.
module tb_pmem_responder;

  localparam int NCH = 2;
  localparam int AW  = 8;
  localparam int DW  = 16;
  localparam int DEP = 64;
  localparam int LAT = 2;

  logic                    clk = 1'b0;
  logic                    reset;
  logic [NCH-1:0]          rv;
  logic [NCH-1:0][AW-1:0]  ra;
  logic [NCH-1:0]          rdy;
  logic [NCH-1:0][DW-1:0]  rdata;
  logic                    ld_v;
  logic [AW-1:0]           ld_a;
  logic [DW-1:0]           ld_d;
`ifdef PMEM_RESP_STATS_EN
  logic [31:0]             stat_resp;
  logic [31:0]             stat_stall;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pmem_responder #(
    .ADDR_BITS    (AW),
    .DATA_BITS    (DW),
    .NUM_CHANNELS (NCH),
    .DEPTH        (DEP),
    .READ_LATENCY (LAT)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .mem_read_valid   (rv),
    .mem_read_address (ra),
    .mem_read_ready   (rdy),
    .mem_read_data    (rdata),
    .load_valid       (ld_v),
    .load_address     (ld_a),
    .load_data        (ld_d)
`ifdef PMEM_RESP_STATS_EN
    ,
    .stat_responses    (stat_resp),
    .stat_stall_cycles (stat_stall)
`endif
  );

  // Reference model: each request is a pending item that becomes servable
  // LAT+1 edges after acceptance; the array is served to one item per edge.
  int            edge_n = 0;
  bit            m_busy [NCH];
  int            m_elig [NCH];
  logic [AW-1:0] m_addr [NCH];
  bit            m_drop [NCH];
  int            m_min  [NCH];
  int            m_ptr;
  logic [DW-1:0] m_mem  [DEP];
  bit            exp_rdy  [NCH];
  logic [DW-1:0] exp_data [NCH];
  int            m_resp;
  int            m_stall;

  task automatic model_edge();
    int e;
    int gi;
    bit stalled;
    e = edge_n;
    edge_n++;
    for (int c = 0; c < NCH; c++) begin
      exp_rdy[c]  = 1'b0;
      exp_data[c] = '0;
    end
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_busy[c] = 1'b0;
        m_drop[c] = 1'b0;
      end
      m_ptr = 0; m_resp = 0; m_stall = 0;
      return;
    end
    gi = -1;
    if (!ld_v) begin
      for (int k = 0; k < NCH; k++) begin
        for (int c = 0; c < NCH; c++) begin
          if (c == (m_ptr + k) % NCH && gi < 0 && m_busy[c] && e >= m_elig[c]) gi = c;
        end
      end
    end
    stalled = 1'b0;
    for (int c = 0; c < NCH; c++) begin
      if (m_busy[c] && e >= m_elig[c] && c != gi) stalled = 1'b1;
    end
    if (stalled) m_stall++;
    for (int c = 0; c < NCH; c++) begin
      if (c == gi) begin
        exp_rdy[c]  = 1'b1;
        exp_data[c] = (m_addr[c] < DEP) ? m_mem[m_addr[c][5:0]] : '0;
        m_busy[c] = 1'b0;
        m_drop[c] = 1'b1;
        m_min[c]  = e + 2;
        m_ptr     = (c + 1) % NCH;
        m_resp++;
      end else if (m_busy[c]) begin
      end else if (m_drop[c]) begin
        if (e >= m_min[c] && !rv[c]) m_drop[c] = 1'b0;
      end else if (rv[c]) begin
        m_busy[c] = 1'b1;
        m_addr[c] = ra[c];
        m_elig[c] = e + LAT + 1;
      end
    end
    if (ld_v && ld_a < DEP) m_mem[ld_a[5:0]] = ld_d;
  endtask

  task automatic tick();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic load_word(input int a, input logic [DW-1:0] d);
    ld_v = 1'b1; ld_a = AW'(a); ld_d = d;
    tick();
    ld_v = 1'b0;
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; rv = '0; ra = '0; ld_v = 1'b0; ld_a = '0; ld_d = '0;
    tick(); tick();
    checks++;
    if (rdy !== 2'b00) begin errors++; $display("FAIL reset_ready: got %b expected 00", rdy); end
    checks++;
    if (rdata !== '0) begin errors++; $display("FAIL reset_data: got %h expected 0", rdata); end
`ifdef PMEM_RESP_STATS_EN
    checks++;
    if (stat_resp !== 32'd0 || stat_stall !== 32'd0) begin
      errors++; $display("FAIL reset_stats: got %0d/%0d expected 0/0", stat_resp, stat_stall);
    end
`endif
    reset = 1'b0;
    for (int a = 0; a < DEP; a++) load_word(a, DW'($urandom));
    load_word(1, 16'hAAAA);
    load_word(2, 16'hBBBB);
    load_word(5, 16'h1234);
    load_word(7, 16'h0F0F);
  endtask

  task automatic test_latency();
    rv[0] = 1'b1; ra[0] = 8'd5;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (rdy !== 2'b00) begin errors++; $display("FAIL latency_early: cycle %0d ready=%b expected 00", i, rdy); end
    end
    tick();
    checks++;
    if (rdy !== 2'b01 || rdata[0] !== 16'h1234) begin
      errors++; $display("FAIL latency_resp: ready=%b data=%h expected 01/1234", rdy, rdata[0]);
    end
    rv[0] = 1'b0;
    tick();
    checks++;
    if (rdy !== 2'b00 || rdata[0] !== 16'h0000) begin
      errors++; $display("FAIL latency_after: ready=%b data=%h expected 00/0000", rdy, rdata[0]);
    end
    idle(4);
  endtask

  task automatic test_rr();
    pulse_reset();
    for (int rep = 0; rep < 2; rep++) begin
      int t0, t1;
      logic [DW-1:0] d0, d1;
      t0 = -1; t1 = -1; d0 = '0; d1 = '0;
      rv = 2'b11; ra[0] = 8'd1; ra[1] = 8'd2;
      for (int i = 0; i < 10; i++) begin
        tick();
        if (rdy[0]) begin t0 = i; d0 = rdata[0]; rv[0] = 1'b0; end
        if (rdy[1]) begin t1 = i; d1 = rdata[1]; rv[1] = 1'b0; end
      end
      rv = '0;
      checks++;
      if (t0 != LAT + 1 || d0 !== 16'hAAAA) begin
        errors++; $display("FAIL rr_ch0 rep%0d: cycle %0d data %h expected %0d/AAAA", rep, t0, d0, LAT + 1);
      end
      checks++;
      if (t1 != LAT + 2 || d1 !== 16'hBBBB) begin
        errors++; $display("FAIL rr_ch1 rep%0d: cycle %0d data %h expected %0d/BBBB", rep, t1, d1, LAT + 2);
      end
      idle(4);
    end
  endtask

  task automatic test_oob();
    int t;
    logic [DW-1:0] d;
    t = -1; d = 16'hFFFF;
    rv[0] = 1'b1; ra[0] = 8'h80;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rdy[0] && t < 0) begin t = i; d = rdata[0]; rv[0] = 1'b0; end
    end
    checks++;
    if (t != LAT + 1 || d !== 16'h0000) begin
      errors++; $display("FAIL oob_read: cycle %0d data %h expected %0d/0000", t, d, LAT + 1);
    end
    idle(3);
  endtask

  task automatic test_load_stall();
    int t;
    logic [DW-1:0] d;
    pulse_reset();
    t = -1; d = '0;
    rv[0] = 1'b1; ra[0] = 8'd7;
    for (int i = 0; i < 12; i++) begin
      if (i >= 3 && i <= 5) begin ld_v = 1'b1; ld_a = 8'd7; ld_d = 16'h4321; end
      else ld_v = 1'b0;
      tick();
      if (rdy[0] && t < 0) begin t = i; d = rdata[0]; rv[0] = 1'b0; end
    end
    ld_v = 1'b0;
    checks++;
    if (t != LAT + 4 || d !== 16'h4321) begin
      errors++; $display("FAIL load_stall: cycle %0d data %h expected %0d/4321", t, d, LAT + 4);
    end
`ifdef PMEM_RESP_STATS_EN
    checks++;
    if (stat_stall !== 32'd3 || stat_resp !== 32'd1) begin
      errors++; $display("FAIL load_stall_stats: stall %0d resp %0d expected 3/1", stat_stall, stat_resp);
    end
`endif
    idle(3);
  endtask

  task automatic test_hold();
    int t, t2, pulses;
    logic [DW-1:0] d;
    t = -1; t2 = -1; pulses = 0; d = '0;
    rv[0] = 1'b1; ra[0] = 8'd5;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (i == 0) ra[0] = 8'd2;
      if (rdy[0]) begin pulses++; if (t < 0) begin t = i; d = rdata[0]; end end
    end
    rv[0] = 1'b0;
    tick();
    rv[0] = 1'b1; ra[0] = 8'd1;
    for (int i = 9; i < 16; i++) begin
      tick();
      if (rdy[0] && t2 < 0) begin t2 = i; rv[0] = 1'b0; end
    end
    rv[0] = 1'b0;
    checks++;
    if (pulses != 1 || t != LAT + 1 || d !== 16'h1234) begin
      errors++; $display("FAIL hold_single: pulses %0d cycle %0d data %h expected 1/%0d/1234", pulses, t, d, LAT + 1);
    end
    checks++;
    if (t2 != 9 + LAT + 1) begin
      errors++; $display("FAIL hold_reaccept: cycle %0d expected %0d", t2, 9 + LAT + 1);
    end
    idle(4);
  endtask

  task automatic test_reset_mid();
    int pulses, t;
    logic [DW-1:0] d;
    pulses = 0; t = -1; d = '0;
    rv[0] = 1'b1; ra[0] = 8'd5;
    tick(); tick();
    rv[0] = 1'b0;
    pulse_reset();
    for (int i = 0; i < 8; i++) begin
      tick();
      if (rdy !== 2'b00) pulses++;
    end
    checks++;
    if (pulses != 0) begin errors++; $display("FAIL reset_abandon: ready pulses %0d expected 0", pulses); end
    rv[0] = 1'b1; ra[0] = 8'd5;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rdy[0] && t < 0) begin t = i; d = rdata[0]; rv[0] = 1'b0; end
    end
    checks++;
    if (t != LAT + 1 || d !== 16'h1234) begin
      errors++; $display("FAIL reset_keeps_array: cycle %0d data %h expected %0d/1234", t, d, LAT + 1);
    end
    idle(4);
  endtask

  task automatic test_random();
    int hold_left [NCH];
    bit seen [NCH];
    for (int c = 0; c < NCH; c++) begin hold_left[c] = 0; seen[c] = 1'b0; end
    for (int cyc = 0; cyc < 800; cyc++) begin
      reset = ($urandom_range(0, 299) == 0);
      if (reset) begin
        rv = '0;
        for (int c = 0; c < NCH; c++) seen[c] = 1'b0;
      end else begin
        for (int c = 0; c < NCH; c++) begin
          if (rv[c]) begin
            if (seen[c]) begin
              if (hold_left[c] == 0) rv[c] = 1'b0;
              else begin hold_left[c]--; ra[c] = AW'($urandom); end
            end
          end else if ($urandom_range(0, 2) == 0) begin
            rv[c] = 1'b1;
            ra[c] = AW'($urandom_range(0, 79));
            seen[c] = 1'b0;
            hold_left[c] = $urandom_range(0, 3);
          end
        end
      end
      ld_v = !reset && ($urandom_range(0, 7) == 0);
      ld_a = AW'($urandom_range(0, 79));
      ld_d = DW'($urandom);
      tick();
      for (int c = 0; c < NCH; c++) begin
        checks++;
        if (rdy[c] !== exp_rdy[c] || rdata[c] !== exp_data[c]) begin
          errors++;
          $display("FAIL random ch%0d cycle %0d: ready=%b data=%h expected %b/%h", c, cyc, rdy[c], rdata[c], exp_rdy[c], exp_data[c]);
        end
        if (exp_rdy[c]) seen[c] = 1'b1;
      end
    end
    reset = 1'b0; ld_v = 1'b0; rv = '0;
    idle(6);
`ifdef PMEM_RESP_STATS_EN
    checks++;
    if (stat_resp !== 32'(m_resp) || stat_stall !== 32'(m_stall)) begin
      errors++; $display("FAIL random_stats: resp %0d stall %0d expected %0d/%0d", stat_resp, stat_stall, m_resp, m_stall);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_latency();
    test_rr();
    test_oob();
    test_load_stall();
    test_hold();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
